// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches words from a small program store and issues them
// to a consumer over a valid/ready handshake, either back-to-back or one per step edge.
// Optional macro SEQ_LOOP_EN: wrap from the last store address to 0 instead of halting.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start; program store writable
// FETCH     | latch store[pc] into instr; halt opcode ends the program
// ISSUE     | instr_valid held until the consumer accepts it
// WAIT_STEP | single-step mode, waiting for a rising edge on step
// HALT      | program finished; done high, pc frozen, store writable
module instr_sequencer #(
    parameter int          DATA_W  = 12,
    parameter int          DEPTH   = 16,
    parameter logic [2:0]  HALT_OP = 3'b111
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              step_i,
    input  logic              run_mode_i,
    input  logic              abort_i,
    input  logic              prog_we_i,
    input  logic [3:0]        prog_addr_i,
    input  logic [DATA_W-1:0] prog_data_i,
    output logic [DATA_W-1:0] instr_o,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [3:0]        pc_o,
    output logic              done_o
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_ISSUE     = 3'd2;
    localparam logic [2:0] S_WAIT_STEP = 3'd3;
    localparam logic [2:0] S_HALT      = 3'd4;

    localparam logic [3:0] LAST_ADDR = 4'(DEPTH - 1);

    logic [DATA_W-1:0] store_q [DEPTH];

    logic [2:0]        state_q, state_d;
    logic [3:0]        pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              step_q;

    logic [DATA_W-1:0] fetch_word;
    logic              is_halt;
    logic              handshake;
    logic              step_rise;
    logic [2:0]        after_issue;

    assign fetch_word  = store_q[pc_q];
    assign is_halt     = (fetch_word[11:9] == HALT_OP);
    assign handshake   = valid_q & instr_ready_i;
    assign step_rise   = step_i & ~step_q;
    assign after_issue = run_mode_i ? S_FETCH : S_WAIT_STEP;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (abort_i) begin
            state_d = S_IDLE;
            pc_d    = 4'd0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d = S_FETCH;
                        pc_d    = 4'd0;
                    end
                end
                S_FETCH: begin
                    instr_d = fetch_word;
                    if (is_halt) begin
                        state_d = S_HALT;
                        valid_d = 1'b0;
                    end else begin
                        state_d = S_ISSUE;
                        valid_d = 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (handshake) begin
                        valid_d = 1'b0;
                        if (pc_q == LAST_ADDR) begin
`ifdef SEQ_LOOP_EN
                            pc_d    = 4'd0;
                            state_d = after_issue;
`else
                            state_d = S_HALT;
`endif
                        end else begin
                            pc_d    = pc_q + 4'd1;
                            state_d = after_issue;
                        end
                    end
                end
                S_WAIT_STEP: begin
                    if (step_rise) begin
                        state_d = S_FETCH;
                    end
                end
                S_HALT: begin
                    if (start_i) begin
                        state_d = S_FETCH;
                        pc_d    = 4'd0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    pc_d    = 4'd0;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
            pc_q    <= 4'd0;
            instr_q <= '0;
            valid_q <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            step_q  <= step_i;
        end
    end

    // Store has no reset so a program survives reset; writes only while not executing.
    always_ff @(posedge clk_i) begin
        if (prog_we_i && (state_q == S_IDLE || state_q == S_HALT)) begin
            store_q[prog_addr_i] <= prog_data_i;
        end
    end

    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;
    assign pc_o          = pc_q;
    assign done_o        = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: expected issues are queued by the stimulus,
// a negedge monitor pops and compares each accepted instruction.
module tb_instr_sequencer;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        start_i, step_i, run_mode_i, abort_i, prog_we_i;
    logic [3:0]  prog_addr_i;
    logic [11:0] prog_data_i;
    logic [11:0] instr_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [3:0]  pc_o;
    logic        done_o;

    typedef struct packed {
        logic [11:0] w;
        logic [3:0]  pc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    instr_sequencer dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .start_i       (start_i),
        .step_i        (step_i),
        .run_mode_i    (run_mode_i),
        .abort_i       (abort_i),
        .prog_we_i     (prog_we_i),
        .prog_addr_i   (prog_addr_i),
        .prog_data_i   (prog_data_i),
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .pc_o          (pc_o),
        .done_o        (done_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (reset_i && instr_valid_o && instr_ready_i && !abort_i) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_issue: got instr=%h pc=%0d, required no issue", instr_o, pc_o);
            end else begin
                mon_e = sb_q.pop_front();
                if (instr_o !== mon_e.w || pc_o !== mon_e.pc) begin
                    n_err++;
                    $display("FAIL issue: got instr=%h pc=%0d, required instr=%h pc=%0d",
                             instr_o, pc_o, mon_e.w, mon_e.pc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic write_word(input logic [3:0] a, input logic [11:0] d);
        prog_we_i   = 1'b1;
        prog_addr_i = a;
        prog_data_i = d;
        tick();
        prog_we_i   = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic push(input logic [11:0] w, input logic [3:0] pc);
        exp_t e;
        e.w  = w;
        e.pc = pc;
        sb_q.push_back(e);
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_o) break;
            tick();
        end
        check(name, {31'd0, done_o}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b0; start_i = 1'b0; step_i = 1'b0; run_mode_i = 1'b1;
        abort_i = 1'b0; prog_we_i = 1'b0; prog_addr_i = 4'd0; prog_data_i = 12'd0;
        instr_ready_i = 1'b1;
        repeat (3) tick();
        check("rst_instr", {20'd0, instr_o}, 32'd0);
        check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        check("rst_pc", {28'd0, pc_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        reset_i = 1'b1;
        tick();

        // Basic run: one instruction, then halt opcode
        write_word(4'd0, 12'h123);
        write_word(4'd1, 12'hE00);
        push(12'h123, 4'd0);
        pulse_start();
        check("lat_valid_c1", {31'd0, instr_valid_o}, 32'd0);
        tick();
        check("lat_valid_c2", {31'd0, instr_valid_o}, 32'd1);
        check("lat_instr_c2", {20'd0, instr_o}, 32'h123);
        tick();
        tick();
        check("halt_done", {31'd0, done_o}, 32'd1);
        check("halt_pc", {28'd0, pc_o}, 32'd1);
        repeat (3) tick();
        check("halt_no_valid", {31'd0, instr_valid_o}, 32'd0);
        check("halt_pc_frozen", {28'd0, pc_o}, 32'd1);

        // Back-pressure during ISSUE
        write_word(4'd0, 12'h111);
        write_word(4'd1, 12'h222);
        write_word(4'd2, 12'hE00);
        instr_ready_i = 1'b0;
        push(12'h111, 4'd0);
        push(12'h222, 4'd1);
        pulse_start();
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", {31'd0, instr_valid_o}, 32'd1);
            check("bp_instr", {20'd0, instr_o}, 32'h111);
            check("bp_pc", {28'd0, pc_o}, 32'd0);
        end
        instr_ready_i = 1'b1;
        tick();
        check("bp_pc_inc", {28'd0, pc_o}, 32'd1);
        wait_done("bp_done", 20);
        check("bp_halt_pc", {28'd0, pc_o}, 32'd2);

        // Single-step with held step level
        write_word(4'd0, 12'h010);
        write_word(4'd1, 12'h020);
        write_word(4'd2, 12'h030);
        write_word(4'd3, 12'hE00);
        run_mode_i = 1'b0;
        push(12'h010, 4'd0);
        pulse_start();
        repeat (5) tick();
        check("step_wait_pc", {28'd0, pc_o}, 32'd1);
        push(12'h020, 4'd1);
        step_i = 1'b1;
        repeat (10) tick();
        step_i = 1'b0;
        check("step_held_once", {28'd0, pc_o}, 32'd2);
        repeat (3) tick();
        push(12'h030, 4'd2);
        step_i = 1'b1;
        repeat (4) tick();
        step_i = 1'b0;
        check("step_repress", {28'd0, pc_o}, 32'd3);
        tick();
        step_i = 1'b1;
        repeat (4) tick();
        step_i = 1'b0;
        check("step_halt_done", {31'd0, done_o}, 32'd1);
        check("step_halt_pc", {28'd0, pc_o}, 32'd3);
        check("step_drained", sb_q.size(), 32'd0);

        // Full store, no halt opcode anywhere
        run_mode_i = 1'b1;
        for (int i = 0; i < 16; i++) write_word(4'(i), 12'h0A0 | 12'(i));
        for (int i = 0; i < 16; i++) push(12'h0A0 | 12'(i), 4'(i));
`ifdef SEQ_LOOP_EN
        push(12'h0A0, 4'd0);
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            tick();
            if (sb_q.size() == 0) break;
        end
        check("loop_reissue", sb_q.size(), 32'd0);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("loop_abort_pc", {28'd0, pc_o}, 32'd0);
        check("loop_abort_done", {31'd0, done_o}, 32'd0);
`else
        pulse_start();
        wait_done("end_done", 200);
        check("end_pc", {28'd0, pc_o}, 32'd15);
        check("end_drained", sb_q.size(), 32'd0);
`endif

        // Abort beats start and handshake during ISSUE
        write_word(4'd0, 12'h055);
        write_word(4'd1, 12'hE00);
        instr_ready_i = 1'b0;
        pulse_start();
        tick();
        check("ab_pre_valid", {31'd0, instr_valid_o}, 32'd1);
        abort_i = 1'b1;
        start_i = 1'b1;
        instr_ready_i = 1'b1;
        tick();
        abort_i = 1'b0;
        start_i = 1'b0;
        check("ab_valid", {31'd0, instr_valid_o}, 32'd0);
        check("ab_pc", {28'd0, pc_o}, 32'd0);
        check("ab_done", {31'd0, done_o}, 32'd0);
        repeat (3) tick();
        check("ab_stays_idle", {31'd0, instr_valid_o}, 32'd0);

        // Writes ignored during ISSUE, store survives reset
        write_word(4'd0, 12'h066);
        write_word(4'd1, 12'h077);
        write_word(4'd2, 12'hE00);
        instr_ready_i = 1'b0;
        pulse_start();
        tick();
        write_word(4'd1, 12'h0FF);
        push(12'h066, 4'd0);
        push(12'h077, 4'd1);
        instr_ready_i = 1'b1;
        wait_done("we_done", 20);
        instr_ready_i = 1'b0;
        pulse_start();
        tick();
        check("rr_pre_valid", {31'd0, instr_valid_o}, 32'd1);
        #2 reset_i = 1'b0;
        #1;
        check("rr_valid", {31'd0, instr_valid_o}, 32'd0);
        check("rr_pc", {28'd0, pc_o}, 32'd0);
        check("rr_instr", {20'd0, instr_o}, 32'd0);
        check("rr_done", {31'd0, done_o}, 32'd0);
        tick();
        reset_i = 1'b1;
        tick();
        instr_ready_i = 1'b1;
        push(12'h066, 4'd0);
        push(12'h077, 4'd1);
        pulse_start();
        wait_done("rr_done_after", 20);
        check("rr_halt_pc", {28'd0, pc_o}, 32'd2);
        check("final_drained", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
